sm_ramp_ctrl: RTL and testbench

Trapezoidal motion scheduler for the stepper-motor pulse generator. It accepts a move command (step count plus ramp profile) and, for each emitted step, updates the period word driven into the generator's `n` input. The profile is accelerate, cruise, decelerate. The block gates the generator enable, counts steps from the generator's pulse output, and supports a soft stop with a decel ramp and an immediate emergency stop.

---
 rtl/sm_pkg.sv | 20 ++
 rtl/sm_ramp_ctrl_if.sv | 34 +++
 rtl/sm_edge_det.sv | 18 +
 rtl/sm_ramp_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_sm_ramp_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/sm_pkg.sv
// Shared types and default widths for the stepper ramp controller.
package sm_pkg;

  localparam int unsigned SIZE  = 16;
  localparam int unsigned CNT_W = 24;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEL  = 3'd1,
    CRUISE = 3'd2,
    DECEL  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // States in which the pulse generator is running.
  function automatic logic is_active(input state_t s);
    return (s == ACCEL) || (s == CRUISE) || (s == DECEL);
  endfunction

endpackage

// File: rtl/sm_ramp_ctrl_if.sv
// Command/status bundle between the motion sequencer and the ramp controller.
interface sm_ramp_ctrl_if #(
  parameter int unsigned SIZE  = sm_pkg::SIZE,
  parameter int unsigned CNT_W = sm_pkg::CNT_W
);

  logic             cmd_start;
  logic             cmd_stop;
  logic             cmd_estop;
  logic [CNT_W-1:0] target_steps;
  logic [SIZE-1:0]  period_start;
  logic [SIZE-1:0]  period_min;
  logic [SIZE-1:0]  period_delta;
  logic             step_in;
  logic [SIZE-1:0]  period;
  logic             run_en;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] pos_cnt;

  modport master (
    output cmd_start, cmd_stop, cmd_estop, target_steps,
           period_start, period_min, period_delta, step_in,
    input  period, run_en, busy, done, aborted, pos_cnt
  );

  modport slave (
    input  cmd_start, cmd_stop, cmd_estop, target_steps,
           period_start, period_min, period_delta, step_in,
    output period, run_en, busy, done, aborted, pos_cnt
  );

endinterface

// File: rtl/sm_edge_det.sv
// Rising-edge detector: registered history, combinational pulse output.
module sm_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise_c
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig;
  end

  assign rise_c = sig & ~sig_q;

endmodule

// File: rtl/sm_ramp_ctrl.sv
// Trapezoidal step-period scheduler: accelerate, cruise, decelerate, with
// soft stop and emergency stop, advanced once per generator step pulse.
module sm_ramp_ctrl #(
  parameter int unsigned SIZE  = sm_pkg::SIZE,
  parameter int unsigned CNT_W = sm_pkg::CNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  sm_ramp_ctrl_if.slave  bus
);

  import sm_pkg::*;

  state_t           state_q, state_d;
  logic [SIZE-1:0]  period_q, period_d;
  logic [SIZE-1:0]  pstart_q, pstart_d;
  logic [SIZE-1:0]  pmin_q, pmin_d;
  logic [SIZE-1:0]  delta_q, delta_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] ramp_q, ramp_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             run_en_q, busy_q, done_q, aborted_q;
  logic             busy_d, done_d, aborted_d;
  logic             abort_evt;
  logic             step_rise_c;

  logic [CNT_W-1:0] rem_new;
  logic [CNT_W-1:0] ramp_dec;
  logic [CNT_W-1:0] ramp_inc;
  logic [CNT_W-1:0] stop_lim;
  logic [SIZE:0]    up_sum;
  logic [SIZE:0]    accel_floor;
  logic [SIZE-1:0]  period_up;

  sm_edge_det u_edge_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig    (bus.step_in),
    .rise_c (step_rise_c)
  );

  assign rem_new     = rem_q - CNT_W'(1);
  assign ramp_dec    = (ramp_q == '0) ? '0 : ramp_q - CNT_W'(1);
  assign ramp_inc    = ramp_q + CNT_W'(1);
  // Wide sums so period+delta and pmin+delta can never wrap.
  assign up_sum      = {1'b0, period_q} + {1'b0, delta_q};
  assign accel_floor = {1'b0, pmin_q} + {1'b0, delta_q};
  assign period_up   = (up_sum > {1'b0, pstart_q}) ? pstart_q : up_sum[SIZE-1:0];

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      period_q  <= '0;
      pstart_q  <= '0;
      pmin_q    <= '0;
      delta_q   <= '0;
      rem_q     <= '0;
      ramp_q    <= '0;
      pos_q     <= '0;
      run_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      pstart_q  <= pstart_d;
      pmin_q    <= pmin_d;
      delta_q   <= delta_d;
      rem_q     <= rem_d;
      ramp_q    <= ramp_d;
      pos_q     <= pos_d;
      run_en_q  <= busy_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    pstart_d  = pstart_q;
    pmin_d    = pmin_q;
    delta_d   = delta_q;
    rem_d     = rem_q;
    ramp_d    = ramp_q;
    pos_d     = pos_q;
    abort_evt = 1'b0;
    stop_lim  = '0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_start) begin
          pstart_d = bus.period_start;
          pmin_d   = (bus.period_min < bus.period_start) ? bus.period_min : bus.period_start;
          delta_d  = bus.period_delta;
          pos_d    = '0;
          if (bus.target_steps != '0) begin
            period_d = bus.period_start;
            rem_d    = bus.target_steps;
            ramp_d   = '0;
            state_d  = ACCEL;
          end else begin
            state_d  = DONE;
          end
        end
      end

      ACCEL, CRUISE, DECEL: begin
        if (bus.cmd_estop) begin
          // A pulse coincident with estop was already emitted, so count it.
          state_d   = IDLE;
          abort_evt = 1'b1;
          if (step_rise_c) pos_d = pos_q + CNT_W'(1);
        end else begin
          if (step_rise_c) begin
            pos_d = pos_q + CNT_W'(1);
            rem_d = rem_new;
            if (rem_new == '0) begin
              state_d = DONE;
            end else begin
              case (state_q)
                ACCEL: begin
                  if (rem_new <= ramp_q) begin
                    state_d  = DECEL;
                    period_d = period_up;
                    ramp_d   = ramp_dec;
                  end else if ({1'b0, period_q} <= accel_floor) begin
                    state_d  = CRUISE;
                    period_d = pmin_q;
                    ramp_d   = ramp_inc;
                  end else begin
                    period_d = period_q - delta_q;
                    ramp_d   = ramp_inc;
                  end
                end
                CRUISE: begin
                  if (rem_new <= ramp_q) begin
                    state_d  = DECEL;
                    period_d = period_up;
                    ramp_d   = ramp_dec;
                  end
                end
                default: begin
                  period_d = period_up;
                  ramp_d   = ramp_dec;
                end
              endcase
            end
          end
          // Soft stop: leave only enough steps to ramp back down.
          if (bus.cmd_stop && (state_q != DECEL) && (state_d != DONE)) begin
            stop_lim = ramp_d + CNT_W'(1);
            if (rem_d > stop_lim) rem_d = stop_lim;
            state_d = DECEL;
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the next state.
  always_comb begin
    busy_d    = is_active(state_d);
    done_d    = (state_d == DONE);
    aborted_d = abort_evt;
  end

  assign bus.period  = period_q;
  assign bus.run_en  = run_en_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;
  assign bus.pos_cnt = pos_q;

endmodule

// File: tb/tb_sm_ramp_ctrl.sv
// Directed bench for sm_ramp_ctrl: trapezoid, triangle, stops, misconfig, reset.
module tb_sm_ramp_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   done_cnt;
  int   abort_cnt;

  sm_ramp_ctrl_if bus ();

  sm_ramp_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled shortly after each rising edge.
  initial begin
    done_cnt  = 0;
    abort_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.done === 1'b1)    done_cnt++;
      if (bus.aborted === 1'b1) abort_cnt++;
    end
  end

  task automatic start_move(input int tgt, input int ps, input int pm, input int pd);
    @(negedge clk);
    bus.target_steps = 24'(tgt);
    bus.period_start = 16'(ps);
    bus.period_min   = 16'(pm);
    bus.period_delta = 16'(pd);
    bus.cmd_start    = 1'b1;
    @(negedge clk);
    bus.cmd_start    = 1'b0;
  endtask

  task automatic step_once();
    @(negedge clk) bus.step_in = 1'b1;
    @(negedge clk) bus.step_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    tests++; if (bus.period !== 16'd0)  begin fails++; $display("FAIL reset_period: got %0d expected 0", bus.period); end
    tests++; if (bus.run_en !== 1'b0)   begin fails++; $display("FAIL reset_run_en: got %b expected 0", bus.run_en); end
    tests++; if (bus.busy !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.done !== 1'b0)     begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    tests++; if (bus.aborted !== 1'b0)  begin fails++; $display("FAIL reset_aborted: got %b expected 0", bus.aborted); end
    tests++; if (bus.pos_cnt !== 24'd0) begin fails++; $display("FAIL reset_pos_cnt: got %0d expected 0", bus.pos_cnt); end
  endtask

  task automatic test_trapezoid(input string tag);
    int exp_p[10] = '{1000, 900, 800, 700, 600, 600, 700, 800, 900, 1000};
    int base;
    start_move(10, 1000, 600, 100);
    base = done_cnt;
    tests++; if (bus.run_en !== 1'b1) begin fails++; $display("FAIL %s run_en_start: got %b expected 1", tag, bus.run_en); end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (bus.period !== 16'(exp_p[i])) begin
        fails++; $display("FAIL %s period step %0d: got %0d expected %0d", tag, i + 1, bus.period, exp_p[i]);
      end
      step_once();
    end
    tests++; if (done_cnt - base !== 1) begin fails++; $display("FAIL %s done_count: got %0d expected 1", tag, done_cnt - base); end
    tests++; if (bus.pos_cnt !== 24'd10) begin fails++; $display("FAIL %s pos_cnt: got %0d expected 10", tag, bus.pos_cnt); end
    tests++; if (bus.run_en !== 1'b0) begin fails++; $display("FAIL %s run_en_end: got %b expected 0", tag, bus.run_en); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL %s busy_end: got %b expected 0", tag, bus.busy); end
  endtask

  task automatic test_triangle();
    int exp_p[4] = '{1000, 900, 800, 900};
    int base;
    start_move(4, 1000, 600, 100);
    base = done_cnt;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (bus.period !== 16'(exp_p[i])) begin
        fails++; $display("FAIL triangle period step %0d: got %0d expected %0d", i + 1, bus.period, exp_p[i]);
      end
      step_once();
    end
    tests++; if (done_cnt - base !== 1) begin fails++; $display("FAIL triangle done_count: got %0d expected 1", done_cnt - base); end
    tests++; if (bus.pos_cnt !== 24'd4) begin fails++; $display("FAIL triangle pos_cnt: got %0d expected 4", bus.pos_cnt); end
  endtask

  task automatic test_soft_stop();
    int exp_p[4] = '{800, 900, 1000, 1000};
    int base;
    start_move(100, 1000, 600, 100);
    base = done_cnt;
    repeat (3) step_once();
    tests++; if (bus.period !== 16'd700) begin fails++; $display("FAIL stop period_before: got %0d expected 700", bus.period); end
    @(negedge clk) bus.cmd_stop = 1'b1;
    @(negedge clk) bus.cmd_stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_once();
      tests++;
      if (bus.period !== 16'(exp_p[i])) begin
        fails++; $display("FAIL stop period after step %0d: got %0d expected %0d", i + 4, bus.period, exp_p[i]);
      end
    end
    tests++; if (done_cnt - base !== 1) begin fails++; $display("FAIL stop done_count: got %0d expected 1", done_cnt - base); end
    tests++; if (bus.pos_cnt !== 24'd7) begin fails++; $display("FAIL stop pos_cnt: got %0d expected 7", bus.pos_cnt); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL stop busy_end: got %b expected 0", bus.busy); end
  endtask

  task automatic test_estop();
    int dbase;
    int abase;
    start_move(50, 1000, 600, 100);
    dbase = done_cnt;
    abase = abort_cnt;
    repeat (5) step_once();
    @(negedge clk);
    bus.step_in   = 1'b1;
    bus.cmd_estop = 1'b1;
    @(negedge clk);
    bus.step_in   = 1'b0;
    bus.cmd_estop = 1'b0;
    tests++; if (bus.aborted !== 1'b1) begin fails++; $display("FAIL estop aborted: got %b expected 1", bus.aborted); end
    tests++; if (bus.run_en !== 1'b0) begin fails++; $display("FAIL estop run_en: got %b expected 0", bus.run_en); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL estop busy: got %b expected 0", bus.busy); end
    tests++; if (bus.pos_cnt !== 24'd6) begin fails++; $display("FAIL estop pos_cnt: got %0d expected 6", bus.pos_cnt); end
    tests++; if (bus.period !== 16'd600) begin fails++; $display("FAIL estop period_hold: got %0d expected 600", bus.period); end
    @(negedge clk);
    tests++; if (bus.aborted !== 1'b0) begin fails++; $display("FAIL estop aborted_len: got %b expected 0", bus.aborted); end
    repeat (4) @(negedge clk);
    tests++; if (done_cnt - dbase !== 0) begin fails++; $display("FAIL estop no_done: got %0d expected 0", done_cnt - dbase); end
    tests++; if (abort_cnt - abase !== 1) begin fails++; $display("FAIL estop abort_count: got %0d expected 1", abort_cnt - abase); end
  endtask

  task automatic test_misconfig();
    int base;
    start_move(3, 1000, 1200, 0);
    base = done_cnt;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (bus.period !== 16'd1000) begin
        fails++; $display("FAIL misconfig period step %0d: got %0d expected 1000", i + 1, bus.period);
      end
      step_once();
    end
    tests++; if (done_cnt - base !== 1) begin fails++; $display("FAIL misconfig done_count: got %0d expected 1", done_cnt - base); end
    tests++; if (bus.pos_cnt !== 24'd3) begin fails++; $display("FAIL misconfig pos_cnt: got %0d expected 3", bus.pos_cnt); end
  endtask

  task automatic test_zero_target();
    start_move(0, 1000, 600, 100);
    tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL zero done: got %b expected 1", bus.done); end
    tests++; if (bus.run_en !== 1'b0) begin fails++; $display("FAIL zero run_en: got %b expected 0", bus.run_en); end
    @(negedge clk);
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL zero done_len: got %b expected 0", bus.done); end
  endtask

  task automatic test_start_while_busy();
    int exp_p[10] = '{1000, 900, 800, 700, 600, 600, 700, 800, 900, 1000};
    start_move(10, 1000, 600, 100);
    repeat (2) step_once();
    start_move(3, 5000, 100, 7);
    tests++; if (bus.period !== 16'd800) begin fails++; $display("FAIL busy_start period: got %0d expected 800", bus.period); end
    for (int i = 2; i < 10; i++) begin
      tests++;
      if (bus.period !== 16'(exp_p[i])) begin
        fails++; $display("FAIL busy_start period step %0d: got %0d expected %0d", i + 1, bus.period, exp_p[i]);
      end
      step_once();
    end
    tests++; if (bus.pos_cnt !== 24'd10) begin fails++; $display("FAIL busy_start pos_cnt: got %0d expected 10", bus.pos_cnt); end
  endtask

  task automatic test_reset_mid_move();
    start_move(10, 1000, 600, 100);
    repeat (3) step_once();
    @(negedge clk);
    bus.step_in = 1'b1;
    rst_n       = 1'b0;
    @(negedge clk);
    bus.step_in = 1'b0;
    rst_n       = 1'b1;
    tests++; if (bus.period !== 16'd0)  begin fails++; $display("FAIL midrst period: got %0d expected 0", bus.period); end
    tests++; if (bus.run_en !== 1'b0)   begin fails++; $display("FAIL midrst run_en: got %b expected 0", bus.run_en); end
    tests++; if (bus.busy !== 1'b0)     begin fails++; $display("FAIL midrst busy: got %b expected 0", bus.busy); end
    tests++; if (bus.pos_cnt !== 24'd0) begin fails++; $display("FAIL midrst pos_cnt: got %0d expected 0", bus.pos_cnt); end
    repeat (2) @(negedge clk);
    test_trapezoid("after_reset");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n            = 1'b0;
    bus.cmd_start    = 1'b0;
    bus.cmd_stop     = 1'b0;
    bus.cmd_estop    = 1'b0;
    bus.target_steps = '0;
    bus.period_start = '0;
    bus.period_min   = '0;
    bus.period_delta = '0;
    bus.step_in      = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_trapezoid("trapezoid");
    test_triangle();
    test_soft_stop();
    test_estop();
    test_misconfig();
    test_zero_target();
    test_start_while_busy();
    test_reset_mid_move();
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
